// File: rtl/sha3_byte_packer.sv
// Packs a UART byte stream into 32-bit words for the keccak core.
// It handles one message per reset, emitting a final word with is_last and byte_num.
module sha3_byte_packer #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               msg_end,
    output logic               rx_ready,
    input  logic               buffer_full,
    output logic [31:0]        in,
    output logic               in_ready,
    output logic               is_last,
    output logic [1:0]         byte_num,
    output logic               done,
    output logic [COUNT_W-1:0] byte_count
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [31:0]        r_acc;
    logic [1:0]         r_cnt;
    logic               r_pend_end;
    logic [1:0]         r_byte_num;
    logic [COUNT_W-1:0] r_byte_count;

    logic               w_fill;
    logic               w_byte_acc;
    logic               w_end_acc;
    logic [31:0]        w_byte_placed;

    assign w_fill        = (r_state == FILL);
    assign w_byte_acc    = rx_valid & w_fill;
    assign w_end_acc     = msg_end & w_fill;
    // First byte of a word lands in the top lane; later bytes move down one lane each.
    assign w_byte_placed = {rx_data, 24'h000000} >> {r_cnt, 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= FILL;
            r_acc      <= 32'h0;
            r_cnt      <= 2'd0;
            r_pend_end <= 1'b0;
            r_byte_num <= 2'd0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_byte_acc) begin
                        r_acc <= r_acc | w_byte_placed;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state    <= SEND;
                            r_pend_end <= w_end_acc;
                        end else if (w_end_acc) begin
                            r_state    <= LAST;
                            r_byte_num <= r_cnt + 2'd1;
                        end
                    end else if (w_end_acc) begin
                        r_state    <= LAST;
                        r_byte_num <= r_cnt;
                    end
                end
                SEND: begin
                    if (!buffer_full) begin
                        r_acc <= 32'h0;
                        r_cnt <= 2'd0;
                        if (r_pend_end) begin
                            // A full final word still needs an empty LAST word behind it.
                            r_state    <= LAST;
                            r_byte_num <= 2'd0;
                            r_pend_end <= 1'b0;
                        end else begin
                            r_state <= FILL;
                        end
                    end
                end
                LAST: begin
                    if (!buffer_full) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= FILL;
                end
            endcase
        end
    end

    // Saturating count of accepted data bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_count <= '0;
        end else if (w_byte_acc && (r_byte_count != {COUNT_W{1'b1}})) begin
            r_byte_count <= r_byte_count + COUNT_W'(1);
        end
    end

    assign rx_ready   = w_fill;
    assign in_ready   = (r_state == SEND) || (r_state == LAST);
    assign is_last    = (r_state == LAST);
    assign in         = in_ready ? r_acc : 32'h0;
    assign byte_num   = r_byte_num;
    assign done       = (r_state == DONE);
    assign byte_count = r_byte_count;

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Directed bench for sha3_byte_packer: each scenario task drives stimulus
// and checks outputs against hand-computed values.
module tb_sha3_byte_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        msg_end;
    logic        rx_ready;
    logic        buffer_full;
    logic [31:0] in;
    logic        in_ready;
    logic        is_last;
    logic [1:0]  byte_num;
    logic        done;
    logic [15:0] byte_count;

    int total;
    int bad;

    sha3_byte_packer #(.COUNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .msg_end    (msg_end),
        .rx_ready   (rx_ready),
        .buffer_full(buffer_full),
        .in         (in),
        .in_ready   (in_ready),
        .is_last    (is_last),
        .byte_num   (byte_num),
        .done       (done),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rx_valid    = 1'b0;
        msg_end     = 1'b0;
        rx_data     = 8'h00;
        buffer_full = 1'b0;
        reset       = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Present one byte (optionally with msg_end) once rx_ready is high.
    task automatic send_byte(input logic [7:0] b, input logic with_end);
        int waited;
        waited = 0;
        while (!rx_ready && waited < 20) begin
            step();
            waited++;
        end
        if (!rx_ready) begin
            total++;
            bad++;
            $display("FAIL send_byte_timeout rx_ready=%0b required=1", rx_ready);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        msg_end  = with_end;
        step();
        rx_valid = 1'b0;
        msg_end  = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_end();
        msg_end = 1'b1;
        step();
        msg_end = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({rx_ready, in_ready, is_last, done} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags got=%b required=1000", {rx_ready, in_ready, is_last, done});
        end
        total++;
        if ({in, byte_num, byte_count} !== 50'h0) begin
            bad++;
            $display("FAIL reset_values in=%h byte_num=%0d byte_count=%0d required all zero",
                     in, byte_num, byte_count);
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_end();
        total++;
        if (in_ready !== 1'b1 || is_last !== 1'b1 || in !== 32'h0 || byte_num !== 2'd0) begin
            bad++;
            $display("FAIL empty_last in_ready=%b is_last=%b in=%h byte_num=%0d required 1 1 00000000 0",
                     in_ready, is_last, in, byte_num);
        end
        step();
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0 || byte_count !== 16'd0) begin
            bad++;
            $display("FAIL empty_done done=%b in_ready=%b byte_count=%0d required 1 0 0",
                     done, in_ready, byte_count);
        end
    endtask

    task automatic test_abc();
        do_reset();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        total++;
        if (in_ready !== 1'b0 || rx_ready !== 1'b1) begin
            bad++;
            $display("FAIL abc_no_word in_ready=%b rx_ready=%b required 0 1", in_ready, rx_ready);
        end
        send_end();
        total++;
        if (is_last !== 1'b1 || in !== 32'h61626300 || byte_num !== 2'd3) begin
            bad++;
            $display("FAIL abc_last is_last=%b in=%h byte_num=%0d required 1 61626300 3",
                     is_last, in, byte_num);
        end
        step();
        total++;
        if (done !== 1'b1 || byte_count !== 16'd3) begin
            bad++;
            $display("FAIL abc_done done=%b byte_count=%0d required 1 3", done, byte_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        buffer_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) buffer_full = 1'b0;
            total++;
            if (in_ready !== 1'b1 || in !== 32'h01020304 || is_last !== 1'b0 || rx_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold_%0d in_ready=%b in=%h is_last=%b rx_ready=%b required 1 01020304 0 0",
                         i, in_ready, in, is_last, rx_ready);
            end
            step();
        end
        total++;
        if (rx_ready !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_release rx_ready=%b in_ready=%b required 1 0", rx_ready, in_ready);
        end
        send_byte(8'h05, 1'b0);
        send_end();
        total++;
        if (is_last !== 1'b1 || in !== 32'h05000000 || byte_num !== 2'd1) begin
            bad++;
            $display("FAIL stall_last is_last=%b in=%h byte_num=%0d required 1 05000000 1",
                     is_last, in, byte_num);
        end
        step();
        total++;
        if (done !== 1'b1 || byte_count !== 16'd5) begin
            bad++;
            $display("FAIL stall_done done=%b byte_count=%0d required 1 5", done, byte_count);
        end
    endtask

    task automatic test_end_with_fourth();
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b1);
        total++;
        if (in_ready !== 1'b1 || is_last !== 1'b0 || in !== 32'hAABBCCDD) begin
            bad++;
            $display("FAIL end4_send in_ready=%b is_last=%b in=%h required 1 0 aabbccdd",
                     in_ready, is_last, in);
        end
        step();
        total++;
        if (in_ready !== 1'b1 || is_last !== 1'b1 || in !== 32'h0 || byte_num !== 2'd0) begin
            bad++;
            $display("FAIL end4_last in_ready=%b is_last=%b in=%h byte_num=%0d required 1 1 00000000 0",
                     in_ready, is_last, in, byte_num);
        end
        step();
        total++;
        if (done !== 1'b1 || byte_count !== 16'd4) begin
            bad++;
            $display("FAIL end4_done done=%b byte_count=%0d required 1 4", done, byte_count);
        end
    endtask

    // Runs straight after test_end_with_fourth, while the block sits in DONE.
    task automatic test_after_done();
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h30 + i);
            msg_end  = i[0];
            step();
            total++;
            if (rx_ready !== 1'b0 || in_ready !== 1'b0 || done !== 1'b1 || byte_count !== 16'd4) begin
                bad++;
                $display("FAIL after_done_%0d rx_ready=%b in_ready=%b done=%b byte_count=%0d required 0 0 1 4",
                         i, rx_ready, in_ready, done, byte_count);
            end
        end
        rx_valid = 1'b0;
        msg_end  = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [2];
        int          wtime [2];
        int          nw;
        int          idx;
        logic [7:0]  b;
        do_reset();
        nw  = 0;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (in_ready && !is_last && nw < 2) begin
                words[nw] = in;
                wtime[nw] = cyc;
                nw++;
            end
            if (rx_ready && idx < 8) begin
                b        = 8'(idx + 1);
                rx_valid = 1'b1;
                rx_data  = b;
                idx++;
            end else begin
                rx_valid = 1'b0;
            end
            step();
        end
        rx_valid = 1'b0;
        total++;
        if (nw !== 2) begin
            bad++;
            $display("FAIL b2b_word_count got=%0d required=2", nw);
        end else begin
            total++;
            if (words[0] !== 32'h01020304 || words[1] !== 32'h05060708) begin
                bad++;
                $display("FAIL b2b_words got=%h,%h required 01020304,05060708", words[0], words[1]);
            end
            total++;
            if (wtime[0] !== 4 || wtime[1] !== 9) begin
                bad++;
                $display("FAIL b2b_timing got=%0d,%0d required 4,9", wtime[0], wtime[1]);
            end
        end
        send_end();
        total++;
        if (is_last !== 1'b1 || in !== 32'h0 || byte_num !== 2'd0 || byte_count !== 16'd8) begin
            bad++;
            $display("FAIL b2b_last is_last=%b in=%h byte_num=%0d byte_count=%0d required 1 0 0 8",
                     is_last, in, byte_num, byte_count);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        buffer_full = 1'b1;
        step();
        total++;
        if (in_ready !== 1'b1 || in !== 32'h11223344) begin
            bad++;
            $display("FAIL rst_send_pre in_ready=%b in=%h required 1 11223344", in_ready, in);
        end
        reset = 1'b1;
        step();
        reset       = 1'b0;
        buffer_full = 1'b0;
        total++;
        if ({rx_ready, in_ready, is_last, done} !== 4'b1000 ||
            in !== 32'h0 || byte_num !== 2'd0 || byte_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_send_post flags=%b in=%h byte_num=%0d byte_count=%0d required 1000 0 0 0",
                     {rx_ready, in_ready, is_last, done}, in, byte_num, byte_count);
        end
        send_byte(8'h61, 1'b1);
        total++;
        if (is_last !== 1'b1 || in !== 32'h61000000 || byte_num !== 2'd1) begin
            bad++;
            $display("FAIL rst_send_new is_last=%b in=%h byte_num=%0d required 1 61000000 1",
                     is_last, in, byte_num);
        end
        step();
        total++;
        if (done !== 1'b1 || byte_count !== 16'd1) begin
            bad++;
            $display("FAIL rst_send_done done=%b byte_count=%0d required 1 1", done, byte_count);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b1;
        rx_valid    = 1'b0;
        msg_end     = 1'b0;
        rx_data     = 8'h00;
        buffer_full = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_stall();
        test_end_with_fourth();
        test_after_done();
        test_back_to_back();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha3_byte_packer.md
# sha3_byte_packer

Upstream feeder for the `keccak` core. It accepts a byte stream from the UART receive path, packs each group of four bytes into one 32-bit word, and presents the words on the core's word interface. It respects `buffer_full` backpressure and, on end-of-message, issues the final partial word with `is_last` and `byte_num`. It handles exactly one message per reset; `keccak` and this block are reset together.

## Interface
- `COUNT_W`, default 16: width of `byte_count`.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `rx_data` in 8: message byte.
- `rx_valid` in 1: `rx_data` is valid this cycle.
- `msg_end` in 1: message terminated. May coincide with `rx_valid`.
- `rx_ready` out 1: byte and `msg_end` are accepted this cycle.
- `buffer_full` in 1: from `keccak`; the word is not consumed while high.
- `in` out 32: word to `keccak`. The first byte of a word is in `in[31:24]`.
- `in_ready` out 1: `in` is valid.
- `is_last` out 1: current word is the final word.
- `byte_num` out 2: number of valid bytes in the final word (0–3). Meaningful only with `is_last`.
- `done` out 1: final word consumed. Sticky until reset.
- `byte_count` out COUNT_W: number of accepted data bytes. Saturates at all-ones.

## Operation
- State register: FILL, SEND, LAST, DONE. It also holds `acc[31:0]`, `cnt[1:0]` and `pend_end`.
- Byte accept: `rx_valid & rx_ready`. End accept: `msg_end & rx_ready`. `rx_ready` = (state == FILL).
- FILL, byte accepted: write `acc[31-8*cnt -: 8]` ← `rx_data`, then `cnt` ← `cnt` + 1 (wraps).
  - If `cnt` was 3, go to SEND.
- FILL, end accepted, no byte: go to LAST with `byte_num` = `cnt`. Bytes of `acc` at and below position `cnt` are zero.
- FILL, byte and end accepted in the same cycle: the byte is part of the message.
  - If `cnt` was 3: go to SEND and set `pend_end`.
  - Otherwise: go to LAST with `byte_num` = `cnt` + 1.
- SEND: `in` = `acc`, `in_ready` = 1, `is_last` = 0.
  - Word is consumed on the first cycle with `buffer_full` = 0.
  - On consume, clear `acc` and `cnt`.
  - Next state is LAST with `byte_num` = 0 if `pend_end` is set, otherwise FILL.
- LAST: `in` = `acc` (unused low bytes zero), `in_ready` = 1, `is_last` = 1. Consumed when `buffer_full` = 0; then go to DONE.
- DONE: `rx_ready` = 0, `in_ready` = 0, `done` = 1. All input is ignored until reset.
- A message length that is a multiple of 4 (including 0) always ends with a LAST word with `byte_num` = 0.
- `in`, `is_last` and `byte_num` are held stable while `in_ready` = 1 and `buffer_full` = 1.
- Outside SEND and LAST: `in_ready` = 0, `is_last` = 0, `in` = 0.
- `byte_count` increments on every byte accept and never wraps.

## Timing
- Reset values: state FILL, `acc` = 0, `cnt` = 0, `pend_end` = 0, `rx_ready` = 1, `in` = 0, `in_ready` = 0, `is_last` = 0, `byte_num` = 0, `done` = 0, `byte_count` = 0.
- All outputs are decoded from registers; there are no combinational paths from input to output.
- Byte 4 accepted at cycle t:
  - `in_ready` = 1 at t+1.
  - If `buffer_full` = 0 at t+1, the word is consumed at t+1 and `rx_ready` = 1 at t+2.
  - Each cycle of `buffer_full` = 1 adds one cycle.
- End accepted at cycle t (no pending word): `in_ready` = `is_last` = 1 at t+1. `done` = 1 the cycle after consume.
- Peak throughput: 4 bytes per 5 cycles with no backpressure.
- Reset asserted in any state, including mid-SEND or mid-LAST: the reset values apply next cycle, and any word not yet consumed is dropped.

## Test plan
- Empty message: `msg_end` only → one word, `in` = 0, `is_last` = 1, `byte_num` = 0; then `done` = 1, `byte_count` = 0.
- "abc" then `msg_end` → LAST word with `in` = 0x61626300, `byte_num` = 3; `keccak` digest equals SHA3-512("abc").
- Bytes 01 02 03 04 05, with `buffer_full` = 1 for 3 cycles when the first word appears:
  - 0x01020304 is held for 4 cycles, then consumed.
  - `rx_ready` stays low throughout the stall.
  - LAST word is 0x05000000 with `byte_num` = 1.
- 4th byte 0xDD with `msg_end` in the same cycle:
  - SEND 0xAABBCCDD with `is_last` = 0.
  - Then LAST with `in` = 0 and `byte_num` = 0.
  - `byte_count` = 4.
- After `done`: further `rx_valid`/`msg_end` pulses → `rx_ready` = 0, `in_ready` never rises, `byte_count` is unchanged.
- Reset asserted while in SEND with `buffer_full` = 1 → next cycle all outputs are at their reset values. A new message "a" then produces a LAST word 0x61000000 with `byte_num` = 1.
